// File: rtl/pwm_timebase.sv
// pwm_timebase: free-running PWM timebase plus update-commit controller.
//
// The prescaler divides clk_i by (eff+1), where eff = max(prescale_i, PRE_MIN),
// and advances a CNT_W-bit counter that wraps modulo 2^CNT_W. Register-file
// updates are held as "pending" and committed only at the period boundary
// (first clock of count 0 after the top count) or immediately while sleeping.
//
// Optional feature macro: PWM_IMMEDIATE_UPDATE_EN
//   When defined, every update request commits on the following edge,
//   regardless of counter position.
module pwm_timebase #(
  parameter int CNT_W   = 12,
  parameter int PRE_W   = 8,
  parameter int PRE_MIN = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic             sleep_i,
  input  logic             update_req_i,
  output logic [CNT_W-1:0] counter_o,
  output logic             tick_o,
  output logic             wrap_o,
  output logic             commit_o,
  output logic             pending_o
);

  localparam logic [CNT_W-1:0] CNT_TOP   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PRE_W-1:0] PRE_FLOOR = PRE_W'(PRE_MIN);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);

  // Commit path: IDLE (nothing waiting) or PENDING (shadow regs hold new data).
  typedef enum logic {
    C_IDLE    = 1'b0,
    C_PENDING = 1'b1
  } cstate_t;

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] eff_q;
  logic [PRE_W-1:0] eff_in;
  logic [CNT_W-1:0] counter_q;
  logic             tick_q;
  logic             wrap_q;
  logic             commit_q;
  cstate_t          cstate;
  logic             advance;
  logic             at_top;
  logic             commit_fire;

  // Clamp the programmed prescale up to the minimum usable divider.
  assign eff_in = (prescale_i < PRE_FLOOR) ? PRE_FLOOR : prescale_i;

  // The compare uses >= so a stale pre_cnt can never run past the period.
  assign advance = !sleep_i && (pre_cnt >= eff_q);
  assign at_top  = (counter_q == CNT_TOP);

`ifdef PWM_IMMEDIATE_UPDATE_EN
  // Every request commits on the next edge; no holdover for later wraps.
  assign commit_fire = update_req_i;
`else
  // Commit at the wrap edge, or on any edge while no period is running.
  assign commit_fire = (cstate == C_PENDING) && (sleep_i || (advance && at_top));
`endif

  // Prescaler and counter. eff is captured only at reload (and during reset
  // or sleep) so a prescale change never truncates the count in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt   <= '0;
      eff_q     <= eff_in;
      counter_q <= '0;
    end else if (sleep_i) begin
      pre_cnt   <= '0;
      eff_q     <= eff_in;
      counter_q <= '0;
    end else if (advance) begin
      pre_cnt   <= '0;
      eff_q     <= eff_in;
      counter_q <= counter_q + CNT_ONE;
    end else begin
      pre_cnt   <= pre_cnt + PRE_ONE;
    end
  end

  // Registered tick/wrap pulses, raised on the advancing edge only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      tick_q <= advance;
      wrap_q <= advance && at_top;
    end
  end

  // Commit FSM: a request coinciding with the commit edge stays pending.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cstate   <= C_IDLE;
      commit_q <= 1'b0;
    end else begin
      commit_q <= commit_fire;
`ifdef PWM_IMMEDIATE_UPDATE_EN
      cstate   <= update_req_i ? C_PENDING : C_IDLE;
`else
      case (cstate)
        C_IDLE:    cstate <= update_req_i ? C_PENDING : C_IDLE;
        C_PENDING: cstate <= (commit_fire && !update_req_i) ? C_IDLE : C_PENDING;
        default:   cstate <= C_IDLE;
      endcase
`endif
    end
  end

  assign counter_o = counter_q;
  assign tick_o    = tick_q;
  assign wrap_o    = wrap_q;
  assign commit_o  = commit_q;
  assign pending_o = (cstate == C_PENDING);

endmodule

// File: tb/tb_pwm_timebase.sv
// tb_pwm_timebase: table-driven checks of the PWM timebase. Each record names
// a clock number (edges since reset release), the expected outputs sampled
// 1ns after that edge, and the inputs to drive for the following edge.
// Expected commit clocks are queued when a request is driven and popped
// whenever commit_o is seen high.
module tb_pwm_timebase;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  prescale = 8'd3;
  logic        sleep = 1'b0;
  logic        update_req = 1'b0;
  logic [11:0] counter;
  logic        tick, wrap, commit, pending;

  pwm_timebase #(.CNT_W(12), .PRE_W(8), .PRE_MIN(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .prescale_i   (prescale),
    .sleep_i      (sleep),
    .update_req_i (update_req),
    .counter_o    (counter),
    .tick_o       (tick),
    .wrap_o       (wrap),
    .commit_o     (commit),
    .pending_o    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst;   // apply a reset instead of a compare
    int n;     // clock number to sample at
    int pre;   // prescale to drive afterwards
    bit slp;   // sleep to drive afterwards
    bit req;   // one-cycle update request afterwards
    int cnt;
    bit tick;
    bit wrap;
    bit pend;
    int cmt;   // expected commit clock for this request (0: none)
  } vec_t;

  vec_t tbl[$];
  int   sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t v(int n, int pre, bit slp, bit req, int cnt,
                             bit tk, bit wr, bit pd, int cmt);
    vec_t e;
    e.rst = 1'b0; e.n = n; e.pre = pre; e.slp = slp; e.req = req;
    e.cnt = cnt; e.tick = tk; e.wrap = wr; e.pend = pd; e.cmt = cmt;
    return e;
  endfunction

  function automatic vec_t r(int pre);
    vec_t e;
    e = v(0, pre, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    e.rst = 1'b1;
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at clock %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock; also matches any commit pulse against the scoreboard.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    update_req = 1'b0;
    if (commit) begin
      if (sb.size() == 0) chk("commit_unexpected", cyc, -1);
      else                chk("commit_clock", cyc, sb.pop_front());
    end
  endtask

  task automatic do_reset(int pre);
    prescale   = pre[7:0];
    sleep      = 1'b0;
    update_req = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_counter", int'(counter), 0);
    chk("rst_tick",    int'(tick), 0);
    chk("rst_wrap",    int'(wrap), 0);
    chk("rst_commit",  int'(commit), 0);
    chk("rst_pending", int'(pending), 0);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // A: eff=3, period 16384 clocks; merge + coincident-request holdover.
    tbl.push_back(r(3));
    tbl.push_back(v(1,     3, 0, 0, 0,    0, 0, 0, 0));
    tbl.push_back(v(3,     3, 0, 0, 0,    0, 0, 0, 0));
    tbl.push_back(v(4,     3, 0, 0, 1,    1, 0, 0, 0));
    tbl.push_back(v(5,     3, 0, 0, 1,    0, 0, 0, 0));
    tbl.push_back(v(8,     3, 0, 0, 2,    1, 0, 0, 0));
    tbl.push_back(v(400,   3, 0, 1, 100,  1, 0, 0, 16384));
    tbl.push_back(v(401,   3, 0, 0, 100,  0, 0, 1, 0));
    tbl.push_back(v(16380, 3, 0, 0, 4095, 1, 0, 1, 0));
    tbl.push_back(v(16383, 3, 0, 1, 4095, 0, 0, 1, 32768));
    tbl.push_back(v(16384, 3, 0, 0, 0,    1, 1, 1, 0));
    tbl.push_back(v(16385, 3, 0, 0, 0,    0, 0, 1, 0));
    tbl.push_back(v(32768, 3, 0, 0, 0,    1, 1, 0, 0));
    tbl.push_back(v(32769, 3, 0, 0, 0,    0, 0, 0, 0));
    // B: prescale 0 clamps to 3; switch to 9 mid-count of value 2.
    tbl.push_back(r(0));
    tbl.push_back(v(3,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(4,  0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(v(8,  0, 0, 0, 2, 1, 0, 0, 0));
    tbl.push_back(v(9,  9, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(v(11, 9, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(v(12, 9, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(v(21, 9, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(v(22, 9, 0, 0, 4, 1, 0, 0, 0));
    tbl.push_back(v(32, 9, 0, 0, 5, 1, 0, 0, 0));
    // C: sleep at count 2000 with a request pending; request while asleep.
    tbl.push_back(r(3));
    tbl.push_back(v(10,   3, 0, 1, 2,    0, 0, 0, 8001));
    tbl.push_back(v(8000, 3, 1, 0, 2000, 1, 0, 1, 0));
    tbl.push_back(v(8001, 3, 1, 1, 0,    0, 0, 0, 8003));
    tbl.push_back(v(8002, 3, 1, 0, 0,    0, 0, 1, 0));
    tbl.push_back(v(8003, 3, 1, 0, 0,    0, 0, 0, 0));
    tbl.push_back(v(8005, 3, 0, 0, 0,    0, 0, 0, 0));
    tbl.push_back(v(8008, 3, 0, 0, 0,    0, 0, 0, 0));
    tbl.push_back(v(8009, 3, 0, 0, 1,    1, 0, 0, 0));
    // D: reset at count 4000 discards the pending request.
    tbl.push_back(r(3));
    tbl.push_back(v(10,    3, 0, 1, 2,    0, 0, 0, 0));
    tbl.push_back(v(16000, 3, 0, 0, 4000, 1, 0, 1, 0));
    tbl.push_back(r(3));
    tbl.push_back(v(16384, 3, 0, 0, 0,    1, 1, 0, 0));
    tbl.push_back(v(16385, 3, 0, 0, 0,    0, 0, 0, 0));

    foreach (tbl[i]) begin
      vec_t e;
      e = tbl[i];
      if (e.rst) begin
        chk("sb_drain", sb.size(), 0);
        sb.delete();
        do_reset(e.pre);
      end else begin
        while (cyc < e.n) step();
        chk($sformatf("e%0d_counter", i), int'(counter), e.cnt);
        chk($sformatf("e%0d_tick", i),    int'(tick),    int'(e.tick));
        chk($sformatf("e%0d_wrap", i),    int'(wrap),    int'(e.wrap));
        chk($sformatf("e%0d_pending", i), int'(pending), int'(e.pend));
        prescale   = e.pre[7:0];
        sleep      = e.slp;
        update_req = e.req;
        if (e.cmt != 0) sb.push_back(e.cmt);
      end
    end
    // A few extra clocks so a late stray commit would still be seen.
    repeat (8) step();
    chk("sb_drain_final", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
